// File: rtl/stonyman_scan_controller_if.sv
// Bundle between the frame-scan sequencer, its frame requester and the ADC controller.
// Strobes are single-cycle pulses sampled on the rising clk edge; there is no backpressure:
// frame_start is honoured only while busy is low, and adc_capture_done only while a capture is pending.
interface stonyman_scan_controller_if;
    logic       frame_start;
    logic       frame_abort;
    logic [7:0] settle_counts;
    logic       adc_capture_done;
    logic       adc_capture_start;
    logic       newline_sample;
    logic       resp;
    logic       incp;
    logic       resv;
    logic       incv;
    logic       busy;
    logic       frame_done;
    logic [7:0] row_idx;
    logic [7:0] col_idx;
    logic [2:0] scan_state;

    modport master (
        output frame_start, frame_abort, settle_counts, adc_capture_done,
        input  adc_capture_start, newline_sample, resp, incp, resv, incv,
               busy, frame_done, row_idx, col_idx, scan_state
    );

    modport slave (
        input  frame_start, frame_abort, settle_counts, adc_capture_done,
        output adc_capture_start, newline_sample, resp, incp, resv, incv,
               busy, frame_done, row_idx, col_idx, scan_state
    );
endinterface

// File: rtl/stonyman_scan_controller.sv
// Stonyman frame-scan sequencer: walks the pixel array with pointer/value pulses,
// waits for the analog output to settle, then hands each pixel to the ADC controller.
module stonyman_scan_controller #(
    parameter int RESOLUTION   = 112,
    parameter int PULSE_CYCLES = 2
) (
    input logic                         clk,
    input logic                         reset,
    stonyman_scan_controller_if.slave   bus
);
    localparam int PCW = $clog2(2 * PULSE_CYCLES) + 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(2 * PULSE_CYCLES - 1);
    localparam logic [PCW-1:0] PULSE_HIGH = PCW'(PULSE_CYCLES);
    localparam logic [7:0]     LAST_IDX   = 8'(RESOLUTION - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PULSE     = 3'd1,
        S_SETTLE    = 3'd2,
        S_CAPTURE   = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_ROW_SETUP = 2'd0,
        PH_COL_SETUP = 2'd1,
        PH_COL_STEP  = 2'd2
    } phase_t;

    state_t         state, state_n;
    phase_t         phase, phase_n;
    logic [8:0]     op_idx, op_idx_n;
    logic [PCW-1:0] pulse_cnt, pulse_cnt_n;
    logic [7:0]     settle_cnt, settle_cnt_n;
    logic [7:0]     row_q, row_n;
    logic [7:0]     col_q, col_n;
    logic           frame_done_q, frame_done_n;
    logic [8:0]     op_last;
    logic [3:0]     line_sel;
    logic           pulse_high;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            phase        <= PH_ROW_SETUP;
            op_idx       <= '0;
            pulse_cnt    <= '0;
            settle_cnt   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            op_idx       <= op_idx_n;
            pulse_cnt    <= pulse_cnt_n;
            settle_cnt   <= settle_cnt_n;
            row_q        <= row_n;
            col_q        <= col_n;
            frame_done_q <= frame_done_n;
        end
    end

    // Operation lists: row setup is resp, incp, resv, then row_q incv; column setup is resp, resv.
    always_comb begin
        op_last  = 9'd0;
        line_sel = 4'b0000;
        case (phase)
            PH_ROW_SETUP: begin
                op_last = 9'd2 + {1'b0, row_q};
                case (op_idx)
                    9'd0:    line_sel = 4'b1000;
                    9'd1:    line_sel = 4'b0100;
                    9'd2:    line_sel = 4'b0010;
                    default: line_sel = 4'b0001;
                endcase
            end
            PH_COL_SETUP: begin
                op_last  = 9'd1;
                line_sel = (op_idx == 9'd0) ? 4'b1000 : 4'b0010;
            end
            PH_COL_STEP: begin
                op_last  = 9'd0;
                line_sel = 4'b0001;
            end
            default: begin
                op_last  = 9'd0;
                line_sel = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_n      = state;
        phase_n      = phase;
        op_idx_n     = op_idx;
        pulse_cnt_n  = pulse_cnt;
        settle_cnt_n = settle_cnt;
        row_n        = row_q;
        col_n        = col_q;
        frame_done_n = 1'b0;

        if (bus.frame_abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        state_n     = S_PULSE;
                        phase_n     = PH_ROW_SETUP;
                        op_idx_n    = '0;
                        pulse_cnt_n = '0;
                        row_n       = '0;
                        col_n       = '0;
                    end
                end
                S_PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        pulse_cnt_n = '0;
                        if (op_idx != op_last) begin
                            op_idx_n = op_idx + 9'd1;
                        end else if (phase == PH_ROW_SETUP) begin
                            phase_n  = PH_COL_SETUP;
                            op_idx_n = '0;
                        end else begin
                            // A zero settle time goes straight to the capture request.
                            settle_cnt_n = '0;
                            state_n      = (bus.settle_counts == 8'd0) ? S_CAPTURE : S_SETTLE;
                        end
                    end else begin
                        pulse_cnt_n = pulse_cnt + PCW'(1);
                    end
                end
                S_SETTLE: begin
                    if ({1'b0, settle_cnt} + 9'd1 >= {1'b0, bus.settle_counts}) begin
                        state_n = S_CAPTURE;
                    end else begin
                        settle_cnt_n = settle_cnt + 8'd1;
                    end
                end
                S_CAPTURE: begin
                    state_n = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.adc_capture_done) begin
                        op_idx_n    = '0;
                        pulse_cnt_n = '0;
                        if (col_q != LAST_IDX) begin
                            col_n   = col_q + 8'd1;
                            phase_n = PH_COL_STEP;
                            state_n = S_PULSE;
                        end else if (row_q != LAST_IDX) begin
                            row_n   = row_q + 8'd1;
                            col_n   = '0;
                            phase_n = PH_ROW_SETUP;
                            state_n = S_PULSE;
                        end else begin
                            frame_done_n = 1'b1;
                            state_n      = S_IDLE;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign pulse_high = (state == S_PULSE) && (pulse_cnt < PULSE_HIGH);

    assign {bus.resp, bus.incp, bus.resv, bus.incv} = pulse_high ? line_sel : 4'b0000;
    assign bus.adc_capture_start = (state == S_CAPTURE);
    assign bus.newline_sample    = (state == S_CAPTURE) && (col_q == 8'd0);
    assign bus.busy              = (state != S_IDLE);
    assign bus.frame_done        = frame_done_q;
    assign bus.row_idx           = row_q;
    assign bus.col_idx           = col_q;
    assign bus.scan_state        = state;
endmodule

// File: tb/tb_stonyman_scan_controller.sv
// Directed bench for the Stonyman scan sequencer: a 4x4 instance with single-cycle pulses
// and a 4x4 instance with two-cycle pulses, each driven by a small ADC controller model.
module tb_stonyman_scan_controller;
    localparam int RES   = 4;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stonyman_scan_controller_if ifa();
    stonyman_scan_controller_if ifb();

    logic       done_a = 1'b0;
    logic       inj_a = 1'b0;
    logic       done_b = 1'b0;
    int         dly_a = 0;
    int         dly_b = 0;
    logic [7:0] settle = 8'd0;

    assign ifa.adc_capture_done = done_a | inj_a;
    assign ifa.settle_counts    = settle;
    assign ifb.adc_capture_done = done_b;
    assign ifb.settle_counts    = 8'd1;

    stonyman_scan_controller #(.RESOLUTION(RES), .PULSE_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    stonyman_scan_controller #(.RESOLUTION(RES), .PULSE_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ADC controller models: capture_done is sampled by the DUT on the third edge after start.
    always @(negedge clk) begin
        done_a = 1'b0;
        if (reset) dly_a = 0;
        else begin
            if (dly_a != 0) begin
                dly_a--;
                if (dly_a == 0) done_a = 1'b1;
            end
            if (ifa.adc_capture_start === 1'b1) dly_a = 2;
        end
    end

    always @(negedge clk) begin
        done_b = 1'b0;
        if (reset) dly_b = 0;
        else begin
            if (dly_b != 0) begin
                dly_b--;
                if (dly_b == 0) done_b = 1'b1;
            end
            if (ifb.adc_capture_start === 1'b1) dly_b = 2;
        end
    end

    // Monitor A: pulse counts, settle gap, scoreboard of captured coordinates.
    int rise_a[4] = '{0, 0, 0, 0};
    int cap_a = 0, nl_a = 0, fd_a = 0, gap_a = 0;
    logic [3:0]  prev_a = 4'b0000;
    logic [3:0]  lines_a;
    logic [16:0] got_a;
    always @(negedge clk) begin
        lines_a = {ifa.resp, ifa.incp, ifa.resv, ifa.incv};
        for (int k = 0; k < 4; k++)
            if (lines_a[k] === 1'b1 && prev_a[k] === 1'b0) rise_a[k]++;
        if (prev_a[0] === 1'b1 && lines_a[0] === 1'b0) gap_a = 0;
        else gap_a++;
        if (ifa.adc_capture_start === 1'b1) begin
            cap_a++;
            if (ifa.newline_sample === 1'b1) nl_a++;
            if (ifa.col_idx != 8'd0) check("settle_gap", gap_a, {24'd0, settle} + 1);
            got_a = {ifa.newline_sample, ifa.row_idx, ifa.col_idx};
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("sb_pixel", got_a, exp_q.pop_front());
        end
        if (ifa.frame_done === 1'b1) begin
            fd_a++;
            check("done_busy_low", ifa.busy, 0);
        end
        prev_a = lines_a;
    end

    // Monitor B: pulse shape with two-cycle pulses.
    int hi_b[4] = '{0, 0, 0, 0};
    int lo_b = 100, cap_b = 0, fd_b = 0;
    logic [3:0] prev_b = 4'b0000;
    logic [3:0] lines_b;
    always @(negedge clk) begin
        lines_b = {ifb.resp, ifb.incp, ifb.resv, ifb.incv};
        if (ifb.busy === 1'b1) check("b_one_line", $countones(lines_b) <= 1, 1);
        for (int k = 0; k < 4; k++) begin
            if (lines_b[k] === 1'b1) begin
                if (prev_b[k] === 1'b0) check("b_low_time", lo_b >= 2, 1);
                hi_b[k]++;
            end else if (prev_b[k] === 1'b1) begin
                check("b_high_time", hi_b[k], 2);
                hi_b[k] = 0;
            end
        end
        if (lines_b === 4'b0000) lo_b++;
        else lo_b = 0;
        if (ifb.adc_capture_start === 1'b1) cap_b++;
        if (ifb.frame_done === 1'b1) fd_b++;
        prev_b = lines_b;
    end

    int b_cap, b_nl, b_fd, b_rise[4];

    task automatic snap_a();
        b_cap = cap_a;
        b_nl  = nl_a;
        b_fd  = fd_a;
        for (int k = 0; k < 4; k++) b_rise[k] = rise_a[k];
    endtask

    task automatic push_frame();
        for (int r = 0; r < RES; r++)
            for (int c = 0; c < RES; c++)
                exp_q.push_back({(c == 0), 8'(r), 8'(c)});
    endtask

    task automatic start_a();
        @(negedge clk) ifa.frame_start = 1'b1;
        @(negedge clk) ifa.frame_start = 1'b0;
        check("start_busy", ifa.busy, 1);
        check("start_resp", ifa.resp, 1);
    endtask

    task automatic wait_frame_a(input string tag);
        for (int i = 0; i < LIMIT && fd_a == b_fd; i++) @(negedge clk);
        check(tag, fd_a - b_fd, 1);
    endtask

    task automatic check_full_frame_a();
        check("captures", cap_a - b_cap, 16);
        check("newlines", nl_a - b_nl, 4);
        check("incv_pulses", rise_a[0] - b_rise[0], 18);
        check("resv_pulses", rise_a[1] - b_rise[1], 8);
        check("incp_pulses", rise_a[2] - b_rise[2], 4);
        check("resp_pulses", rise_a[3] - b_rise[3], 8);
        check("busy_after", ifa.busy, 0);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        ifa.frame_start = 1'b0;
        ifa.frame_abort = 1'b0;
        ifb.frame_start = 1'b0;
        ifb.frame_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", ifa.busy, 0);
        check("rst_lines", {ifa.resp, ifa.incp, ifa.resv, ifa.incv}, 0);
        check("rst_capture", {ifa.adc_capture_start, ifa.newline_sample, ifa.frame_done}, 0);
        check("rst_row_col", {ifa.row_idx, ifa.col_idx}, 0);
        check("rst_state", ifa.scan_state, 0);
        check("rst_b_busy", ifb.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Plain frame, no settle wait.
        snap_a();
        push_frame();
        start_a();
        wait_frame_a("frame1_done");
        check_full_frame_a();

        // Settle of 5; a second frame_start while busy must be ignored.
        settle = 8'd5;
        snap_a();
        push_frame();
        start_a();
        repeat (20) @(negedge clk);
        ifa.frame_start = 1'b1;
        @(negedge clk) ifa.frame_start = 1'b0;
        wait_frame_a("frame2_done");
        check_full_frame_a();
        repeat (5) @(negedge clk);
        check("no_extra_done", fd_a - b_fd, 1);

        // capture_done injected during a pulse and during settle.
        settle = 8'd3;
        snap_a();
        push_frame();
        start_a();
        for (int i = 0; i < LIMIT && !(ifa.scan_state == 3'd1 && ifa.col_idx == 8'd1); i++)
            @(negedge clk);
        check("reach_pulse", ifa.scan_state, 1);
        inj_a = 1'b1;
        @(negedge clk) inj_a = 1'b0;
        check("pulse_done_ignored", ifa.col_idx, 1);
        for (int i = 0; i < LIMIT && ifa.scan_state != 3'd2; i++) @(negedge clk);
        check("reach_settle", ifa.scan_state, 2);
        inj_a = 1'b1;
        @(negedge clk) inj_a = 1'b0;
        check("settle_done_ignored", ifa.col_idx, 1);
        wait_frame_a("frame3_done");
        check("captures_spurious", cap_a - b_cap, 16);
        check("sb_drained3", exp_q.size(), 0);

        // Abort in the seventh capture's wait.
        settle = 8'd0;
        snap_a();
        push_frame();
        start_a();
        for (int i = 0; i < LIMIT && !(cap_a - b_cap == 7 && ifa.scan_state == 3'd4); i++)
            @(negedge clk);
        check("reach_wait7", ifa.scan_state, 4);
        ifa.frame_abort = 1'b1;
        @(negedge clk) ifa.frame_abort = 1'b0;
        check("abort_busy", ifa.busy, 0);
        check("abort_lines", {ifa.resp, ifa.incp, ifa.resv, ifa.incv}, 0);
        repeat (6) @(negedge clk);
        check("abort_no_done", fd_a - b_fd, 0);
        check("abort_captures", cap_a - b_cap, 7);
        exp_q.delete();

        // frame_start together with frame_abort in idle: no frame.
        ifa.frame_start = 1'b1;
        ifa.frame_abort = 1'b1;
        @(negedge clk);
        ifa.frame_start = 1'b0;
        ifa.frame_abort = 1'b0;
        check("start_abort_idle", ifa.busy, 0);

        snap_a();
        push_frame();
        start_a();
        wait_frame_a("frame4_done");
        check_full_frame_a();

        // Reset mid-row while incv is high.
        snap_a();
        push_frame();
        start_a();
        for (int i = 0; i < LIMIT && !(ifa.incv === 1'b1 && ifa.row_idx == 8'd1 && ifa.col_idx == 8'd2); i++)
            @(negedge clk);
        check("reach_incv", ifa.incv, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_lines", {ifa.resp, ifa.incp, ifa.resv, ifa.incv}, 0);
        check("mid_rst_outs", {ifa.busy, ifa.adc_capture_start, ifa.newline_sample, ifa.frame_done}, 0);
        check("mid_rst_row_col", {ifa.row_idx, ifa.col_idx}, 0);
        @(negedge clk) reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        snap_a();
        push_frame();
        start_a();
        wait_frame_a("frame5_done");
        check_full_frame_a();

        // Two-cycle pulses on the second instance.
        begin
            int fd0, cap0;
            fd0  = fd_b;
            cap0 = cap_b;
            @(negedge clk) ifb.frame_start = 1'b1;
            @(negedge clk) ifb.frame_start = 1'b0;
            check("b_start_busy", ifb.busy, 1);
            for (int i = 0; i < LIMIT && fd_b == fd0; i++) @(negedge clk);
            check("b_frame_done", fd_b - fd0, 1);
            check("b_captures", cap_b - cap0, 16);
            check("b_busy_after", ifb.busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/stonyman_scan_controller.md
# stonyman_scan_controller

Frame-scan sequencer for the Stonyman image sensor, sitting directly upstream of the ADC controller. Walks the pixel array row by row by pulsing the sensor's pointer/value lines (resp/incp/resv/incv), waits for each pixel's analog output to settle, then requests a conversion. It moves to the next pixel when the ADC controller signals its track phase is over. Also generates the per-line marker the ADC controller uses to index its line buffer.

## Interface
- RESOLUTION, 112: pixels per row and rows per frame; row/col counters are 8 bits, so RESOLUTION ≤ 255.
- PULSE_CYCLES, 2: high time and low time, in clk cycles, of every sensor-line pulse (≥1).
- clk  input  1  system clock (40 MHz fabric clock).
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle request to scan a frame; honoured only in IDLE.
- frame_abort  input  1  abandons the current frame; returns to IDLE.
- settle_counts  input  8  cycles to wait after the last pointer/value pulse before requesting a capture; 0 means no wait.
- adc_capture_done  input  1  one-cycle pulse from the ADC controller: sample taken, pixel may change.
- adc_capture_start  output  1  one-cycle capture request to the ADC controller.
- newline_sample  output  1  high for exactly the cycle adc_capture_start is issued for column 0 of any row.
- resp, incp, resv, incv  output  1 each  Stonyman pointer-reset, pointer-increment, value-reset and value-increment lines (active high).
- busy  output  1  high from the cycle after frame_start until return to IDLE.
- frame_done  output  1  one-cycle pulse when the last pixel's capture_done is received.
- row_idx, col_idx  output  8 each  coordinates of the pixel currently selected.

## Operation
- Sensor registers: pointer 0 = COLSEL, pointer 1 = ROWSEL.
- Pulse primitive: the line goes high for PULSE_CYCLES cycles, then low for PULSE_CYCLES cycles. Only one line pulses at a time.
- States: IDLE, PULSE, SETTLE, CAPTURE, WAIT_DONE.
  - PULSE executes the next entry of an operation list.
  - A sub-phase register (ROW_SETUP, COL_SETUP, COL_STEP) selects that list.
- Row setup for row r:
  - resp, incp (pointer = ROWSEL), resv, then r incv pulses.
  - Then COL_SETUP: resp (pointer = COLSEL), resv (col 0).
  - Then SETTLE.
- SETTLE: counts settle_counts cycles, then goes to CAPTURE.
- CAPTURE: asserts adc_capture_start for one cycle, plus newline_sample if col_idx = 0. Then goes to WAIT_DONE.
- WAIT_DONE, on adc_capture_done:
  - col < RESOLUTION-1: col_idx+1, one incv pulse (COL_STEP), then SETTLE.
  - col = RESOLUTION-1 and row < RESOLUTION-1: row_idx+1, col_idx = 0, row setup.
  - Last pixel: frame_done pulse, go to IDLE.
- adc_capture_done outside WAIT_DONE is ignored.
- frame_start while busy is ignored.
- frame_abort has priority over everything except reset:
  - Next cycle: state IDLE, all sensor lines low, no frame_done.
  - frame_start and frame_abort together in IDLE: the frame does not start.
- Reset values: all outputs 0, row_idx = col_idx = 0, state IDLE. Reset mid-pulse drops the line low at the next edge.

## Timing
- frame_start at edge N: busy = 1 and resp = 1 from edge N+1.
- Each pulse occupies 2·PULSE_CYCLES cycles.
- Row setup for row r: (r+5)·2·PULSE_CYCLES cycles.
- Column step: 2·PULSE_CYCLES cycles.
- From the last pulse's final low cycle to adc_capture_start: settle_counts+1 cycles.
- adc_capture_done at edge M:
  - Next pulse line rises at M+1.
  - On the last pixel, frame_done = 1 at M+1 and busy = 0 at M+1.
- row_idx/col_idx update on the edge that leaves WAIT_DONE and are stable through the following capture.

## Test plan
- RESOLUTION=4, PULSE_CYCLES=1, settle=0, ADC model returns done 3 cycles after start, one frame:
  - 16 adc_capture_start pulses, 4 newline_sample pulses.
  - Exactly 18 incv, 8 resp, 4 incp, 8 resv pulses.
  - One frame_done; busy low afterwards.
- settle_counts=5: gap from incv falling to adc_capture_start is exactly 6 cycles for every mid-row pixel.
- Assert adc_capture_done during a PULSE and during SETTLE: ignored; col_idx is unchanged; the scan still completes with 16 captures.
- frame_abort at the 7th capture's WAIT_DONE:
  - busy = 0 next cycle, all lines low, no frame_done.
  - A following frame_start scans all 16 pixels starting at (0,0).
- reset asserted mid-row while incv is high: next cycle all outputs 0; frame_start afterwards behaves like the first scenario.
- PULSE_CYCLES=2: every resp/incp/resv/incv high time is exactly 2 cycles and low time ≥2 cycles; never two lines high simultaneously.
